clfsr_stream_cipher: RTL and testbench
======================================

CLFSR_STREAM_CIPHER -- requirements
Module: clfsr_stream_cipher

Interface
REQ-001 SHALL have parameter DISCARD, default 64: number of keystream bits dropped after reset or restart before any bit is collected (warm-up), range 0..1023.
REQ-002 SHALL have parameter KS_DEPTH, default 4: depth of the keystream byte FIFO, power of two, 2..16.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port ks_bit, input, 1 bit: keystream bit from the chaotic-LFSR generator output, one new bit every clk cycle, no handshake.
REQ-006 SHALL have port restart, input, 1 bit: synchronous request to flush keystream state and re-enter warm-up.
REQ-007 SHALL have port pt_valid, input, 1 bit: plaintext byte valid.
REQ-008 SHALL have port pt_data, input, 8 bits: plaintext byte.
REQ-009 SHALL have port pt_ready, output, 1 bit: block accepts plaintext this cycle.
REQ-010 SHALL have port ct_valid, output, 1 bit: ciphertext byte valid.
REQ-011 SHALL have port ct_data, output, 8 bits: ciphertext byte.
REQ-012 SHALL have port ct_ready, input, 1 bit: downstream accepts ciphertext.
REQ-013 SHALL have port ks_level, output, 5 bits: current keystream FIFO occupancy, 0..KS_DEPTH.
REQ-014 SHALL have port warm, output, 1 bit: 1 while in WARMUP state.

Function
REQ-015 SHALL implement a two-state FSM, WARMUP and RUN.
REQ-016 WARMUP SHALL count sampled ks_bit cycles, discard them, and move to RUN on the cycle the DISCARD-th bit is sampled; with DISCARD=0 it SHALL go straight to RUN after one cycle.
REQ-017 In RUN, each cycle with FIFO not full SHALL shift ks_bit into an 8-bit collector, MSB first: the first collected bit ends up in bit 7 of the byte.
REQ-018 The cycle the 8th bit is sampled, the completed byte SHALL be pushed into the FIFO and the bit counter SHALL wrap to 0; the byte SHALL be poppable from the next cycle.
REQ-019 When the FIFO is full, ks_bit SHALL be discarded and the collector and bit counter SHALL hold; no partial byte SHALL be corrupted.
REQ-020 pt_ready SHALL equal (state==RUN) AND (ks_level!=0) AND (ct_valid==0 OR ct_ready==1), purely combinational from registers and ct_ready.
REQ-021 A plaintext transfer (pt_valid AND pt_ready) SHALL pop one keystream byte and register ct_data = pt_data XOR popped byte, with ct_valid=1 on the next cycle (latency 1).
REQ-022 ct_valid/ct_data SHALL hold stable while ct_valid=1 and ct_ready=0; a ct transfer with no new pt transfer SHALL clear ct_valid.
REQ-023 A simultaneous push (byte completion) and pop in the same cycle SHALL leave ks_level unchanged; a push while full SHALL never occur because of REQ-019.
REQ-024 Keystream bytes SHALL be consumed strictly in FIFO order; pointers SHALL wrap modulo KS_DEPTH.
REQ-025 restart=1 SHALL, on the next edge, empty the FIFO, clear the collector, bit and warm-up counters, enter WARMUP and drop any pt transfer in that cycle (pt_ready forced 0 while restart=1); a ct_valid already pending SHALL be kept until transferred.
REQ-026 ks_bit SHALL not be sampled during reset; sampling starts on the first rising edge after rst deasserts.

Reset
REQ-027 rst=1 SHALL asynchronously set state=WARMUP, all counters 0, FIFO empty, collector 0, ct_valid=0, ct_data=0x00, so pt_ready=0, ks_level=0 and warm=1.
REQ-028 Asserting rst mid-transfer SHALL discard all pending keystream and ciphertext with no output glitch beyond the async clear.

Verification
REQ-029 DISCARD=64, ks_bit=1 constant, pt_valid=0 after reset -> warm=1 for 64 cycles, first byte pushed 8 cycles later, ks_level counts up to 4 and holds; pt_ready=1 once ks_level>=1.
REQ-030 ks_bit pattern 1,0,1,0,0,1,0,1 after warm-up; pt 0x5A -> ct_data=0x5A XOR 0xA5=0xFF one cycle after acceptance.
REQ-031 FIFO full, ct_ready=0, pt_valid=1 for 3 cycles -> exactly one pt accepted, ct_valid held with unchanged ct_data, ks_level drops by 1 only.
REQ-032 Simultaneous byte completion and pt pop with ks_level=2 -> ks_level stays 2; ciphertext uses the oldest byte.
REQ-033 restart pulse at ks_level=3 with 5 collector bits and ct_valid=1 -> ks_level=0, warm=1, pt_ready=0, pending ct still delivered on ct_ready=1.
REQ-034 rst asserted asynchronously between edges during RUN -> all outputs immediately at REQ-027 values; full warm-up repeats afterward.

Source files
------------

// File: rtl/clfsr_stream_cipher.sv
// Stream cipher back end: warms up on the chaotic-LFSR bit stream, packs keystream
// bits into bytes, buffers them in a small FIFO and XORs them onto plaintext bytes.
module clfsr_stream_cipher #(
    parameter int unsigned DISCARD  = 64,
    parameter int unsigned KS_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ks_bit,
    input  logic       restart,
    input  logic       pt_valid,
    input  logic [7:0] pt_data,
    output logic       pt_ready,
    output logic       ct_valid,
    output logic [7:0] ct_data,
    input  logic       ct_ready,
    output logic [4:0] ks_level,
    output logic       warm
);

    localparam int unsigned PW        = (KS_DEPTH > 1) ? $clog2(KS_DEPTH) : 1;
    // DISCARD=0 shares the single-cycle warm-up of DISCARD=1
    localparam logic [9:0]  WARM_LAST  = (DISCARD == 0) ? 10'd0 : 10'(DISCARD - 1);
    localparam logic [4:0]  FULL_LEVEL = 5'(KS_DEPTH);

    typedef enum logic {WARMUP, RUN} state_t;

    state_t        state;
    logic [9:0]    warm_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    collector;
    logic [7:0]    fifo_mem [KS_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          push;
    logic          pop;
    logic [7:0]    next_byte;

    always_comb begin
        full      = (ks_level == FULL_LEVEL);
        next_byte = {collector[6:0], ks_bit};
        push      = (state == RUN) && !full && (bit_cnt == 3'd7);
        pt_ready  = (state == RUN) && (ks_level != '0) && (!ct_valid || ct_ready) && !restart;
        pop       = pt_valid && pt_ready;
        warm      = (state == WARMUP);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= next_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= WARMUP;
            warm_cnt  <= '0;
            bit_cnt   <= '0;
            collector <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ks_level  <= '0;
            ct_valid  <= 1'b0;
            ct_data   <= '0;
        end else begin
            // The output register keeps its own handshake even across a restart
            if (pop) begin
                ct_data  <= pt_data ^ fifo_mem[rd_ptr];
                ct_valid <= 1'b1;
            end else if (ct_ready) begin
                ct_valid <= 1'b0;
            end

            if (restart) begin
                state     <= WARMUP;
                warm_cnt  <= '0;
                bit_cnt   <= '0;
                collector <= '0;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                ks_level  <= '0;
            end else begin
                case (state)
                    WARMUP: begin
                        if (warm_cnt == WARM_LAST) begin
                            state    <= RUN;
                            warm_cnt <= '0;
                        end else begin
                            warm_cnt <= warm_cnt + 10'd1;
                        end
                    end
                    RUN: begin
                        if (!full) begin
                            collector <= next_byte;
                            bit_cnt   <= bit_cnt + 3'd1;
                        end
                    end
                    default: state <= WARMUP;
                endcase

                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      ks_level <= ks_level + 5'd1;
                else if (pop && !push) ks_level <= ks_level - 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_clfsr_stream_cipher.sv
// Directed bench for clfsr_stream_cipher: warm-up timing, byte packing, FIFO
// occupancy, output back-pressure, restart and asynchronous reset behaviour.
module tb_clfsr_stream_cipher;

    logic       clk = 1'b0;
    logic       rst;
    logic       ks_bit;
    logic       restart;
    logic       pt_valid;
    logic [7:0] pt_data;
    logic       pt_ready;
    logic       ct_valid;
    logic [7:0] ct_data;
    logic       ct_ready;
    logic [4:0] ks_level;
    logic       warm;

    int errors = 0;
    int checks = 0;

    clfsr_stream_cipher #(.DISCARD(64), .KS_DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .ks_bit   (ks_bit),
        .restart  (restart),
        .pt_valid (pt_valid),
        .pt_data  (pt_data),
        .pt_ready (pt_ready),
        .ct_valid (ct_valid),
        .ct_data  (ct_data),
        .ct_ready (ct_ready),
        .ks_level (ks_level),
        .warm     (warm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Shifts the top n bits of b into ks_bit, MSB first
    task automatic feed_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            ks_bit = b[i];
            tick(1);
        end
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        ks_bit   = 1'b1;
        restart  = 1'b0;
        pt_valid = 1'b0;
        pt_data  = 8'h00;
        ct_ready = 1'b0;
        #2;
        chk("rst_warm",     32'(warm), 32'd1);
        chk("rst_level",    32'(ks_level), 32'd0);
        chk("rst_pt_ready", 32'(pt_ready), 32'd0);
        chk("rst_ct_valid", 32'(ct_valid), 32'd0);
        chk("rst_ct_data",  32'(ct_data), 32'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Warm-up: 64 discarded bits, then one byte per 8 cycles up to full
        tick(63);
        chk("wu_warm_63", 32'(warm), 32'd1);
        tick(1);
        chk("wu_warm_64", 32'(warm), 32'd0);
        chk("wu_level_64", 32'(ks_level), 32'd0);
        tick(7);
        chk("first_byte_7", 32'(ks_level), 32'd0);
        chk("pt_ready_empty", 32'(pt_ready), 32'd0);
        tick(1);
        chk("first_byte_8", 32'(ks_level), 32'd1);
        chk("pt_ready_lvl1", 32'(pt_ready), 32'd1);
        tick(8);
        chk("level_2", 32'(ks_level), 32'd2);
        tick(16);
        chk("level_4", 32'(ks_level), 32'd4);
        tick(8);
        chk("level_hold_full", 32'(ks_level), 32'd4);

        // Back-pressure while full: only one plaintext byte accepted
        pt_valid = 1'b1;
        pt_data  = 8'h12;
        tick(1);
        chk("bp_ct_valid_a", 32'(ct_valid), 32'd1);
        chk("bp_ct_data_a",  32'(ct_data), 32'hED);
        chk("bp_level_a",    32'(ks_level), 32'd3);
        chk("bp_pt_ready_a", 32'(pt_ready), 32'd0);
        tick(2);
        chk("bp_ct_valid_c", 32'(ct_valid), 32'd1);
        chk("bp_ct_data_c",  32'(ct_data), 32'hED);
        chk("bp_level_c",    32'(ks_level), 32'd3);

        // Restart with level 3, 5 collected bits and a pending ciphertext byte
        pt_valid = 1'b0;
        tick(3);
        chk("rs_pre_level", 32'(ks_level), 32'd3);
        restart  = 1'b1;
        pt_valid = 1'b1;
        #1;
        chk("rs_pt_ready_gated", 32'(pt_ready), 32'd0);
        tick(1);
        restart  = 1'b0;
        pt_valid = 1'b0;
        chk("rs_level", 32'(ks_level), 32'd0);
        chk("rs_warm", 32'(warm), 32'd1);
        chk("rs_pt_ready", 32'(pt_ready), 32'd0);
        chk("rs_ct_kept_valid", 32'(ct_valid), 32'd1);
        chk("rs_ct_kept_data", 32'(ct_data), 32'hED);
        ct_ready = 1'b1;
        tick(1);
        chk("rs_ct_delivered", 32'(ct_valid), 32'd0);
        tick(62);
        chk("rs_warm_63", 32'(warm), 32'd1);
        tick(1);
        chk("rs_warm_64", 32'(warm), 32'd0);
        feed_bits(8'h81, 7);
        chk("rs_bitcnt_cleared", 32'(ks_level), 32'd0);
        ks_bit = 1'b1;
        tick(1);
        chk("rs_byte_pushed", 32'(ks_level), 32'd1);
        pt_valid = 1'b1;
        pt_data  = 8'h00;
        tick(1);
        pt_valid = 1'b0;
        chk("rs_byte_value", 32'(ct_data), 32'h81);

        // Bit ordering: 1,0,1,0,0,1,0,1 -> 0xA5, XOR 0x5A -> 0xFF
        do_restart();
        tick(64);
        chk("pat_warm", 32'(warm), 32'd0);
        feed_bits(8'hA5, 8);
        chk("pat_level", 32'(ks_level), 32'd1);
        pt_valid = 1'b1;
        pt_data  = 8'h5A;
        tick(1);
        pt_valid = 1'b0;
        chk("pat_ct_valid", 32'(ct_valid), 32'd1);
        chk("pat_ct_data",  32'(ct_data), 32'hFF);
        chk("pat_level_pop", 32'(ks_level), 32'd0);
        tick(1);
        chk("pat_ct_cleared", 32'(ct_valid), 32'd0);

        // Simultaneous push and pop at level 2, bytes consumed oldest first
        do_restart();
        tick(64);
        feed_bits(8'h3C, 8);
        feed_bits(8'hC3, 8);
        chk("sim_level_pre", 32'(ks_level), 32'd2);
        feed_bits(8'h96, 7);
        ks_bit   = 1'b0;
        pt_valid = 1'b1;
        pt_data  = 8'h00;
        tick(1);
        chk("sim_level_same", 32'(ks_level), 32'd2);
        chk("sim_ct_oldest", 32'(ct_data), 32'h3C);
        pt_data = 8'h0F;
        tick(1);
        chk("sim_ct_second", 32'(ct_data), 32'hCC);
        chk("sim_level_1", 32'(ks_level), 32'd1);
        pt_data = 8'h00;
        tick(1);
        chk("sim_ct_third", 32'(ct_data), 32'h96);
        chk("sim_level_0", 32'(ks_level), 32'd0);
        pt_valid = 1'b0;

        // Asynchronous reset between edges during RUN
        ks_bit = 1'b1;
        tick(20);
        pt_valid = 1'b1;
        ct_ready = 1'b0;
        tick(1);
        pt_valid = 1'b0;
        chk("ar_pre_ct_valid", 32'(ct_valid), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_warm",     32'(warm), 32'd1);
        chk("ar_level",    32'(ks_level), 32'd0);
        chk("ar_pt_ready", 32'(pt_ready), 32'd0);
        chk("ar_ct_valid", 32'(ct_valid), 32'd0);
        chk("ar_ct_data",  32'(ct_data), 32'h00);
        #2;
        rst = 1'b0;
        tick(63);
        chk("ar_warm_63", 32'(warm), 32'd1);
        tick(1);
        chk("ar_warm_64", 32'(warm), 32'd0);
        tick(8);
        chk("ar_first_byte", 32'(ks_level), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
